// File: rtl/rs422_uart_rx.sv
// 8N1 UART receiver for the RS422 link, 16x oversampled on the 1.8432 MHz clock.
// Each bit is sampled at its centre; line transitions re-centre the sample counter.
module rs422_uart_rx #(
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8
) (
   input  logic                 clk1_8m,
   input  logic                 rst,
   input  logic                 rxd,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 frame_err,
   output logic                 busy
);

   localparam int CW = $clog2(OVERSAMPLE);
   localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [CW-1:0] CNT_MID    = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] CNT_LAST   = CW'(OVERSAMPLE - 1);
   localparam logic [CW-1:0] CNT_RESYNC = CW'(OVERSAMPLE / 2);
   localparam logic [IW-1:0] IDX_LAST   = IW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      DONE,
      BREAK
   } state_t;

   state_t               state, state_nxt;
   logic                 rxd_meta, rxd_s, rxd_d;
   logic [CW-1:0]        cnt, cnt_nxt;
   logic [IW-1:0]        idx, idx_nxt;
   logic [DATA_BITS-1:0] shreg;
   logic                 shift_en, load_en, err_en;
   logic                 line_edge;

   // rxd_d is one cycle behind rxd_s, so line_edge marks a bit boundary
   always_ff @(posedge clk1_8m or negedge rst) begin
      if (!rst) begin
         rxd_meta <= 1'b1;
         rxd_s    <= 1'b1;
         rxd_d    <= 1'b1;
      end else begin
         rxd_meta <= rxd;
         rxd_s    <= rxd_meta;
         rxd_d    <= rxd_s;
      end
   end

   assign line_edge = rxd_s ^ rxd_d;

   always_ff @(posedge clk1_8m or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= '0;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         idx   <= idx_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + CW'(1);
      idx_nxt   = idx;
      shift_en  = 1'b0;
      load_en   = 1'b0;
      err_en    = 1'b0;
      case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (!rxd_s) state_nxt = START;
         end
         START: begin
            if (cnt == CNT_MID) begin
               cnt_nxt   = '0;
               idx_nxt   = '0;
               state_nxt = rxd_s ? IDLE : DATA;
            end
         end
         DATA: begin
            // An edge lands half a bit before the next centre at the nominal rate
            if (cnt == CNT_LAST) begin
               cnt_nxt  = '0;
               shift_en = 1'b1;
               if (idx == IDX_LAST) state_nxt = STOP;
               else                 idx_nxt   = idx + IW'(1);
            end else if (line_edge) begin
               cnt_nxt = CNT_RESYNC;
            end
         end
         STOP: begin
            if (cnt == CNT_LAST) begin
               cnt_nxt = '0;
               if (rxd_s) begin
                  state_nxt = DONE;
               end else begin
                  err_en    = 1'b1;
                  state_nxt = BREAK;
               end
            end else if (line_edge) begin
               cnt_nxt = CNT_RESYNC;
            end
         end
         DONE: begin
            cnt_nxt   = '0;
            load_en   = 1'b1;
            state_nxt = IDLE;
         end
         BREAK: begin
            cnt_nxt = '0;
            if (rxd_s) state_nxt = IDLE;
         end
         default: begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk1_8m) begin
      if (shift_en) shreg <= {rxd_s, shreg[DATA_BITS-1:1]};
   end

   always_ff @(posedge clk1_8m or negedge rst) begin
      if (!rst) begin
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         rx_valid  <= load_en;
         frame_err <= err_en;
         if (load_en) rx_data <= shreg;
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_rs422_uart_rx.sv
// Directed bench for rs422_uart_rx: nominal, glitch, break, back-to-back,
// off-rate and mid-frame reset cases with hand-computed expectations.
`timescale 1ns/1ps
module tb_rs422_uart_rx;

   logic       clk1_8m = 1'b0;
   logic       rst;
   logic       rxd;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       busy;

   int         cyc = 0;
   int         n_checks = 0;
   int         n_pass = 0;
   int         n_valid = 0;
   int         n_ferr = 0;
   int         n_both = 0;
   int         valid_cyc = 0;
   int         start_cyc = 0;
   logic       busy_seen = 1'b0;
   logic [7:0] vlog[$];

   rs422_uart_rx #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
      .clk1_8m  (clk1_8m),
      .rst      (rst),
      .rxd      (rxd),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .frame_err(frame_err),
      .busy     (busy)
   );

   always #271 clk1_8m = ~clk1_8m;

   always @(posedge clk1_8m) cyc <= cyc + 1;

   always @(negedge clk1_8m) begin
      if (rx_valid) begin
         n_valid   = n_valid + 1;
         valid_cyc = cyc;
         vlog.push_back(rx_data);
      end
      if (frame_err) n_ferr = n_ferr + 1;
      if (rx_valid && frame_err) n_both = n_both + 1;
      if (busy) busy_seen = 1'b1;
   end

   task automatic check(input string tag, input int act, input int exp);
      n_checks = n_checks + 1;
      if (act == exp) n_pass = n_pass + 1;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
   endtask

   task automatic idle(input int n);
      rxd = 1'b1;
      repeat (n) @(negedge clk1_8m);
   endtask

   task automatic clear_mon();
      n_valid   = 0;
      n_ferr    = 0;
      busy_seen = 1'b0;
      vlog.delete();
   endtask

   task automatic send_frame(input logic [7:0] b, input int per, input logic stop_bit);
      rxd = 1'b0;
      repeat (per) @(negedge clk1_8m);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (per) @(negedge clk1_8m);
      end
      rxd = stop_bit;
      repeat (per) @(negedge clk1_8m);
   endtask

   initial begin
      int lat;
      rst = 1'b1;
      rxd = 1'b1;
      #10 rst = 1'b0;
      repeat (4) @(negedge clk1_8m);
      check("rst_data",  rx_data,   0);
      check("rst_valid", rx_valid,  0);
      check("rst_ferr",  frame_err, 0);
      check("rst_busy",  busy,      0);
      rst = 1'b1;
      idle(8);

      // Nominal 0xA5 frame
      clear_mon();
      start_cyc = cyc + 1;
      send_frame(8'hA5, 16, 1'b1);
      idle(20);
      lat = valid_cyc - start_cyc;
      check("a5_count", n_valid, 1);
      check("a5_data",  rx_data, 8'hA5);
      check("a5_ferr",  n_ferr,  0);
      check("a5_lat_in_range", int'(lat >= 154 && lat <= 156), 1);
      check("a5_busy_seen", busy_seen, 1);
      check("a5_busy_after", busy, 0);

      // Short low glitch rejected as a false start
      clear_mon();
      rxd = 1'b0;
      repeat (4) @(negedge clk1_8m);
      idle(30);
      check("gl_busy_seen", busy_seen, 1);
      check("gl_count", n_valid, 0);
      check("gl_ferr",  n_ferr,  0);
      check("gl_data",  rx_data, 8'hA5);
      check("gl_busy",  busy,    0);

      // 0x3C with low stop bit, then line held low
      clear_mon();
      send_frame(8'h3C, 16, 1'b0);
      repeat (40) @(negedge clk1_8m);
      check("brk_ferr",  n_ferr,  1);
      check("brk_count", n_valid, 0);
      check("brk_data",  rx_data, 8'hA5);
      check("brk_busy",  busy,    1);
      idle(30);
      check("brk_ferr_after",  n_ferr,  1);
      check("brk_count_after", n_valid, 0);
      check("brk_idle",        busy,    0);

      // Back-to-back frames, no idle between them
      clear_mon();
      send_frame(8'h00, 16, 1'b1);
      send_frame(8'hFF, 16, 1'b1);
      send_frame(8'h81, 16, 1'b1);
      idle(30);
      check("b2b_count", n_valid, 3);
      check("b2b_ferr",  n_ferr,  0);
      if (vlog.size() >= 3) begin
         check("b2b_d0", vlog[0], 8'h00);
         check("b2b_d1", vlog[1], 8'hFF);
         check("b2b_d2", vlog[2], 8'h81);
      end else begin
         check("b2b_log_size", vlog.size(), 3);
      end

      // Off-rate bit periods
      clear_mon();
      send_frame(8'h5A, 15, 1'b1);
      idle(30);
      check("p15_count", n_valid, 1);
      check("p15_data",  rx_data, 8'h5A);
      check("p15_ferr",  n_ferr,  0);
      clear_mon();
      send_frame(8'h5A, 17, 1'b1);
      idle(30);
      check("p17_count", n_valid, 1);
      check("p17_data",  rx_data, 8'h5A);
      check("p17_ferr",  n_ferr,  0);

      // Reset in the middle of data bit 4 of 0xC3
      clear_mon();
      rxd = 1'b0;
      repeat (16) @(negedge clk1_8m);
      for (int i = 0; i < 4; i++) begin
         rxd = (8'hC3 >> i) & 8'h01;
         repeat (16) @(negedge clk1_8m);
      end
      rxd = 1'b0;
      repeat (8) @(negedge clk1_8m);
      rst = 1'b0;
      repeat (2) @(negedge clk1_8m);
      check("mr_data",  rx_data,   0);
      check("mr_valid", rx_valid,  0);
      check("mr_ferr",  frame_err, 0);
      check("mr_busy",  busy,      0);
      rxd = 1'b1;
      repeat (4) @(negedge clk1_8m);
      rst = 1'b1;
      idle(40);
      check("mr_no_strobe", n_valid, 0);
      check("mr_no_ferr",   n_ferr,  0);
      clear_mon();
      send_frame(8'h6E, 16, 1'b1);
      idle(30);
      check("mr_6e_count", n_valid, 1);
      check("mr_6e_data",  rx_data, 8'h6E);
      check("mr_6e_ferr",  n_ferr,  0);

      check("never_both", n_both, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/rs422_uart_rx.md
Name: rs422_uart_rx

Overview:
- UART receiver for the RS422 link. Deserialises 8N1 frames arriving on the line at 115200 baud.
- Oversamples 16x, directly on the 1.8432 MHz system clock. This is the same 16:1 ratio the baud divider uses to generate the transmit bit clock.
- Presents each received byte with a single-cycle valid strobe. Flags a stop-bit (framing) error.

Parameters:
- OVERSAMPLE, 16, clocks per bit. Power of two, 8..16.
- DATA_BITS, 8, data bits per frame. LSB first.

Ports:
- clk1_8m  input  1  system clock, 1.8432 MHz. All logic is on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- rxd  input  1  serial line input. Asynchronous. Idles high.
- rx_data  output  DATA_BITS  last correctly framed byte. Held until the next good frame.
- rx_valid  output  1  one-cycle pulse: rx_data has just been updated.
- frame_err  output  1  one-cycle pulse: stop bit was sampled low.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst low, asynchronous):
  - State is IDLE; the sample counter and bit index are 0.
  - rx_data=0, rx_valid=0, frame_err=0, busy=0.
  - Both synchroniser flops reset to 1.
- Input path: 2-flop synchroniser on rxd, giving rxd_s. All decisions use rxd_s only. No majority vote.
- Counter: sample counter cnt, log2(OVERSAMPLE) bits, wraps naturally. Bit index 0..DATA_BITS-1.
- States and transitions:
  - IDLE: when rxd_s==0, go to START with cnt=0. Otherwise stay.
  - START: cnt increments each cycle. At cnt==OVERSAMPLE/2-1 (mid start bit):
    - rxd_s==0: go to DATA, cnt=0, index=0.
    - rxd_s==1: glitch; go to IDLE. No output activity.
  - DATA: at cnt==OVERSAMPLE-1, shift rxd_s into the shift register MSB (so the result is LSB-first) and reset cnt to 0.
    - After sampling bit DATA_BITS-1, go to STOP.
  - STOP: at cnt==OVERSAMPLE-1, sample the stop bit.
    - rxd_s==1: on the next edge, rx_data is loaded from the shift register, rx_valid=1 for one cycle, then go to IDLE.
    - rxd_s==0: frame_err=1 for one cycle, rx_data unchanged, rx_valid stays 0, then go to BREAK.
  - BREAK: wait until rxd_s==1, then go to IDLE. This prevents a held-low line (break) from being decoded as repeated 0x00 frames.
- Sampling: every data and stop bit is sampled at its nominal centre.
- Latency, first-rxd-low clock to rx_valid high: 2 + OVERSAMPLE/2 + OVERSAMPLE*(DATA_BITS+1) + 1 cycles, ±1 for synchroniser phase. Default is 155 cycles.
- Back-to-back frames:
  - IDLE is re-entered half a bit before the stop-bit end, so a start edge immediately after the stop bit is caught.
  - Minimum supported frame spacing: 1 stop bit, zero idle.
- Exclusivity: rx_valid and frame_err are never high in the same cycle.
- Baud tolerance: frames are received correctly with bit periods of 15..17 clocks (±6%).
- Reset mid-frame aborts immediately. The partial byte is discarded and no strobe is issued. The next complete frame after reset release is received normally.

Test Plan:
- Reset, then an 8N1 frame carrying 0xA5 at 16 clk/bit -> rx_valid is a single pulse 155±1 cycles after the start edge, rx_data=0xA5, frame_err stays 0, busy falls after the strobe.
- rxd low for 4 cycles, then high -> busy pulses briefly, returns to IDLE; no rx_valid, no frame_err; rx_data unchanged.
- Frame 0x3C with stop bit forced low, rxd then held low 40 cycles -> frame_err is a single pulse, rx_data unchanged (previous value), no rx_valid; no further strobes until rxd returns high.
- Back-to-back frames 0x00, 0xFF, 0x81 with one stop bit and no idle between them -> exactly three rx_valid pulses with data 0x00, 0xFF, 0x81 in order.
- Frame 0x5A at a bit period of 15 clocks, then again at 17 clocks -> rx_data=0x5A both times, no frame_err.
- Assert rst during data bit 4 of a 0xC3 frame, release, then send 0x6E -> outputs are 0 during reset, no strobe for the aborted frame, rx_data=0x6E with one rx_valid.
